// File: rtl/alu_op_issue_if.sv
// ALU issue bundle: registered operands/control with valid/ready handshake.
// master drives the payload toward the ALU, slave consumes it.
interface alu_op_issue_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic [4:0]  alu_control;
  logic [4:0]  rd;
  logic        reg_write;
  logic        illegal;

  modport master (
    output out_valid, operand_1, operand_2,
    output alu_control, rd, reg_write, illegal,
    input  out_ready
  );

  modport slave (
    input  out_valid, operand_1, operand_2,
    input  alu_control, rd, reg_write, illegal,
    output out_ready
  );
endinterface

// File: rtl/alu_op_issue.sv
// ID/EX issue stage: decodes RV32I/M into ALU control and operands,
// holding them in a valid/ready register slice with flush and op counter.
module alu_op_issue #(
  parameter int unsigned ENABLE_MUL = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic             flush,
  alu_op_issue_if.master   alu,
  output logic [CNT_W-1:0] issued_count
);
  localparam logic [4:0] C_ADD  = 5'b00000;
  localparam logic [4:0] C_SUB  = 5'b00010;
  localparam logic [4:0] C_SLL  = 5'b00100;
  localparam logic [4:0] C_SLT  = 5'b01000;
  localparam logic [4:0] C_SLTU = 5'b01100;
  localparam logic [4:0] C_XOR  = 5'b10000;
  localparam logic [4:0] C_SRL  = 5'b10100;
  localparam logic [4:0] C_SRA  = 5'b10110;
  localparam logic [4:0] C_OR   = 5'b11000;
  localparam logic [4:0] C_AND  = 5'b11100;
  localparam logic [4:0] C_MUL  = 5'b01010;

  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] u_imm;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign i_imm  = {{20{instr[31]}}, instr[31:20]};
  assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign u_imm  = {instr[31:12], 12'b0};

  logic is_op, is_imm, is_load, is_store, is_lui, is_auipc;

  assign is_op    = opcode == 7'b0110011;
  assign is_imm   = opcode == 7'b0010011;
  assign is_load  = opcode == 7'b0000011;
  assign is_store = opcode == 7'b0100011;
  assign is_lui   = opcode == 7'b0110111;
  assign is_auipc = opcode == 7'b0010111;

  logic [4:0]  base;
  logic [31:0] d_op1;
  logic [31:0] d_op2;
  logic [4:0]  d_code;
  logic        d_ill;
  logic        d_rw;

  always_comb begin
    base = C_ADD;
    case (f3)
      3'b001:  base = C_SLL;
      3'b010:  base = C_SLT;
      3'b011:  base = C_SLTU;
      3'b100:  base = C_XOR;
      3'b101:  base = C_SRL;
      3'b110:  base = C_OR;
      3'b111:  base = C_AND;
      default: base = C_ADD;
    endcase
  end

  always_comb begin
    d_op1  = '0;
    d_op2  = '0;
    d_code = C_ADD;
    d_ill  = 1'b0;
    unique case (1'b1)
      is_op: begin
        d_op1 = rs1_data;
        d_op2 = rs2_data;
        if (f7 == 7'b0)
          d_code = base;
        else if (f7 == F7_ALT && f3 == 3'b000)
          d_code = C_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101)
          d_code = C_SRA;
        else if (f7 == F7_MUL && f3 == 3'b000
                 && ENABLE_MUL != 0)
          d_code = C_MUL;
        else
          d_ill = 1'b1;
      end
      is_imm: begin
        d_op1  = rs1_data;
        d_op2  = i_imm;
        d_code = base;
        // shift-immediates reuse the upper imm bits as funct7
        if (f3 == 3'b001 && f7 != 7'b0)
          d_ill = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == F7_ALT)
            d_code = C_SRA;
          else if (f7 != 7'b0)
            d_ill = 1'b1;
        end
      end
      is_load: begin
        d_op1 = rs1_data;
        d_op2 = i_imm;
      end
      is_store: begin
        d_op1 = rs1_data;
        d_op2 = s_imm;
      end
      is_lui: begin
        d_op2 = u_imm;
      end
      is_auipc: begin
        d_op1 = pc;
        d_op2 = u_imm;
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_op1  = '0;
      d_op2  = '0;
      d_code = C_ADD;
    end
    d_rw = !d_ill && !is_store
        && instr[11:7] != 5'd0;
  end

  logic        q_valid;
  logic [31:0] q_op1;
  logic [31:0] q_op2;
  logic [4:0]  q_code;
  logic [4:0]  q_rd;
  logic        q_rw;
  logic        q_ill;
  logic        accept;

  assign in_ready = !flush && (!q_valid || alu.out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid      <= 1'b0;
      q_op1        <= '0;
      q_op2        <= '0;
      q_code       <= '0;
      q_rd         <= '0;
      q_rw         <= 1'b0;
      q_ill        <= 1'b0;
      issued_count <= '0;
    end else begin
      if (flush)
        q_valid <= 1'b0;
      else if (accept) begin
        q_valid <= 1'b1;
        q_op1   <= d_op1;
        q_op2   <= d_op2;
        q_code  <= d_code;
        q_rd    <= instr[11:7];
        q_rw    <= d_rw;
        q_ill   <= d_ill;
      end else if (alu.out_ready)
        q_valid <= 1'b0;
      if (q_valid && alu.out_ready && !flush)
        issued_count <= issued_count + 1'b1;
    end
  end

  assign alu.out_valid   = q_valid;
  assign alu.operand_1   = q_op1;
  assign alu.operand_2   = q_op2;
  assign alu.alu_control = q_code;
  assign alu.rd          = q_rd;
  assign alu.reg_write   = q_rw;
  assign alu.illegal     = q_ill;
endmodule
